move_job_dispatcher: RTL and testbench

// Initiator for the piece move-generator accelerators. CPU stages jobs {src_board, dest_board, x, y} here, not in the accelerator.

---
 rtl/chessmate_accel_pkg.sv | 30 +++
 rtl/job_fifo.sv | 53 +++++
 rtl/move_job_dispatcher.sv | 184 ++++++++++++++++++
 tb/tb_move_job_dispatcher.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chessmate_accel_pkg.sv
// rtl/chessmate_accel_pkg.sv - shared register map, job record and dispatcher FSM states
package chessmate_accel_pkg;

    localparam logic [3:0] REG_CTRL      = 4'd0;
    localparam logic [3:0] REG_SRC_BOARD = 4'd1;
    localparam logic [3:0] REG_DST_BOARD = 4'd2;
    localparam logic [3:0] REG_SRC_X     = 4'd3;
    localparam logic [3:0] REG_SRC_Y     = 4'd4;
    localparam logic [3:0] REG_JOBS_DONE = 4'd5;
    localparam logic [3:0] REG_LAST_CYC  = 4'd6;

    localparam logic [31:0] ADDR_IDLE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  x;
        logic [7:0]  y;
    } move_job_t;

    typedef enum logic [3:0] {
        IDLE, POP, WR_SRC, WR_DST, WR_X, WR_Y, WR_GO, GAP, RD_DONE, RETIRE
    } disp_state_t;

    // Byte address of accelerator word index idx.
    function automatic logic [31:0] accel_addr(input logic [31:0] base, input logic [3:0] idx);
        return base + {26'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/job_fifo.sv
// rtl/job_fifo.sv - synchronous first-word-fall-through job FIFO
module job_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot it reads, so a push into a full FIFO may land the same cycle.
    assign do_push = push && (!full || do_pop);

    // Storage array, no reset needed since count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/move_job_dispatcher.sv
// rtl/move_job_dispatcher.sv - queues CPU move jobs and replays them to the accelerator
module move_job_dispatcher
    import chessmate_accel_pkg::*;
#(
    parameter logic [31:0] ACCEL_BASE = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    disp_state_t   state;
    move_job_t     staged_job;
    move_job_t     cur_job;
    move_job_t     head_job;
    logic [31:0]   stage_src;
    logic [31:0]   stage_dst;
    logic [7:0]    stage_x;
    logic [7:0]    stage_y;
    logic [31:0]   cyc_cnt;
    logic [31:0]   jobs_done;
    logic [31:0]   last_job_cycles;
    logic [CW-1:0] fifo_count;
    logic [3:0]    count4;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          push_req;
    logic          clear_jobs;
    logic          busy;
    logic          accel_rdata_unused;

    // The accelerator's done-read carries no data; completion is the handshake itself.
    assign accel_rdata_unused = ^master_readdata;

    assign staged_job        = '{src: stage_src, dst: stage_dst, x: stage_x, y: stage_y};
    assign push_req          = slave_write && (slave_address == REG_CTRL);
    assign clear_jobs        = slave_write && (slave_address == REG_JOBS_DONE);
    assign fifo_pop          = (state == POP);
    assign slave_waitrequest = push_req && fifo_full && !fifo_pop;
    assign busy              = (state != IDLE) || (fifo_count != '0);
    assign count4            = 4'(fifo_count);

    job_fifo #(
        .WIDTH ($bits(move_job_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_job_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (staged_job),
        .pop       (fifo_pop),
        .head      (head_job),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Staging registers hold their values across pushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_src <= '0;
            stage_dst <= '0;
            stage_x   <= '0;
            stage_y   <= '0;
        end else if (slave_write) begin
            case (slave_address)
                REG_SRC_BOARD: stage_src <= slave_writedata;
                REG_DST_BOARD: stage_dst <= slave_writedata;
                REG_SRC_X:     stage_x   <= slave_writedata[7:0];
                REG_SRC_Y:     stage_y   <= slave_writedata[7:0];
                default: ;
            endcase
        end
    end

    // CPU register read mux.
    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                REG_CTRL:      slave_readdata = {24'd0, count4, 2'd0, fifo_full, busy};
                REG_SRC_BOARD: slave_readdata = stage_src;
                REG_DST_BOARD: slave_readdata = stage_dst;
                REG_SRC_X:     slave_readdata = {24'd0, stage_x};
                REG_SRC_Y:     slave_readdata = {24'd0, stage_y};
                REG_JOBS_DONE: slave_readdata = jobs_done;
                REG_LAST_CYC:  slave_readdata = last_job_cycles;
                default:       slave_readdata = '0;
            endcase
        end
    end

    // Job replay FSM with registered master strobes, per-job cycle counter and completion count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            master_write     <= 1'b0;
            master_read      <= 1'b0;
            master_address   <= ADDR_IDLE;
            master_writedata <= '0;
            cur_job          <= '0;
            cyc_cnt          <= '0;
            jobs_done        <= '0;
            last_job_cycles  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) state <= POP;
                end
                POP: begin
                    cur_job          <= head_job;
                    cyc_cnt          <= '0;
                    master_write     <= 1'b1;
                    master_address   <= accel_addr(ACCEL_BASE, REG_SRC_BOARD);
                    master_writedata <= head_job.src;
                    state            <= WR_SRC;
                end
                WR_SRC: if (!master_waitrequest) begin
                    master_address   <= accel_addr(ACCEL_BASE, REG_DST_BOARD);
                    master_writedata <= cur_job.dst;
                    state            <= WR_DST;
                end
                WR_DST: if (!master_waitrequest) begin
                    master_address   <= accel_addr(ACCEL_BASE, REG_SRC_X);
                    master_writedata <= {24'd0, cur_job.x};
                    state            <= WR_X;
                end
                WR_X: if (!master_waitrequest) begin
                    master_address   <= accel_addr(ACCEL_BASE, REG_SRC_Y);
                    master_writedata <= {24'd0, cur_job.y};
                    state            <= WR_Y;
                end
                WR_Y: if (!master_waitrequest) begin
                    master_address   <= accel_addr(ACCEL_BASE, REG_CTRL);
                    master_writedata <= 32'd1;
                    state            <= WR_GO;
                end
                WR_GO: if (!master_waitrequest) begin
                    master_write     <= 1'b0;
                    master_address   <= ADDR_IDLE;
                    master_writedata <= '0;
                    state            <= GAP;
                end
                GAP: begin
                    master_read    <= 1'b1;
                    master_address <= accel_addr(ACCEL_BASE, REG_CTRL);
                    state          <= RD_DONE;
                end
                RD_DONE: if (!master_waitrequest) begin
                    master_read    <= 1'b0;
                    master_address <= ADDR_IDLE;
                    state          <= RETIRE;
                end
                RETIRE: begin
                    jobs_done       <= jobs_done + 32'd1;
                    last_job_cycles <= cyc_cnt;
                    state           <= fifo_empty ? IDLE : POP;
                end
                default: state <= IDLE;
            endcase
            if ((state inside {WR_SRC, WR_DST, WR_X, WR_Y, WR_GO, GAP, RD_DONE}) && (cyc_cnt != 32'hFFFF_FFFF)) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            // A CPU clear beats a coincident retire.
            if (clear_jobs) jobs_done <= '0;
        end
    end

endmodule

// File: tb/tb_move_job_dispatcher.sv
// tb/tb_move_job_dispatcher.sv - directed self-checking bench for move_job_dispatcher
module tb_move_job_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_write;
    logic [31:0] master_writedata;

    int assertions = 0;
    int failures   = 0;
    int cyc_no     = 0;

    logic [64:0] log_q[$];
    int          go_cycle = 0;
    int          rd_first = 0;
    int          rd_run = 0;
    int          last_rd_len = 0;

    logic        stall_all  = 1'b0;
    logic        rand_mode  = 1'b0;
    logic [31:0] stall_addr = 32'hFFFF_FFF0;
    int          rd_hold    = 0;
    int          rd_cnt     = 0;

    move_job_dispatcher dut (
        .clk                (clk),
        .rst                (rst),
        .slave_waitrequest  (slave_waitrequest),
        .slave_address      (slave_address),
        .slave_read         (slave_read),
        .slave_readdata     (slave_readdata),
        .slave_write        (slave_write),
        .slave_writedata    (slave_writedata),
        .master_waitrequest (master_waitrequest),
        .master_address     (master_address),
        .master_read        (master_read),
        .master_readdata    (master_readdata),
        .master_write       (master_write),
        .master_writedata   (master_writedata)
    );

    always #5 clk = ~clk;

    // Accelerator slave model: decides waitrequest at each falling edge.
    initial begin
        master_waitrequest = 1'b0;
        master_readdata    = 32'd0;
        forever begin
            @(negedge clk);
            if (master_read === 1'b1) begin
                if (stall_all) master_waitrequest = 1'b1;
                else if (rd_cnt < rd_hold) begin
                    master_waitrequest = 1'b1;
                    rd_cnt++;
                end else master_waitrequest = 1'b0;
            end else begin
                rd_cnt = 0;
                if (master_write === 1'b1)
                    master_waitrequest = stall_all || (master_address == stall_addr) ||
                                         (rand_mode && ($urandom_range(0, 1) == 1));
                else
                    master_waitrequest = 1'b0;
            end
        end
    end

    // Bus monitor: logs accepted transfers and checks stalled writes stay frozen.
    logic        pw = 1'b0, pwait = 1'b0, prst = 1'b1;
    logic [31:0] pa = '0, pd = '0;
    always @(posedge clk) begin
        cyc_no++;
        if (pw && pwait && !prst) begin
            assertions++;
            if (!(master_write === 1'b1 && master_address === pa && master_writedata === pd)) begin
                failures++;
                $display("FAIL stall_hold: write=%b addr=%h data=%h, required write=1 addr=%h data=%h",
                         master_write, master_address, master_writedata, pa, pd);
            end
        end
        if (!rst && master_write === 1'b1 && master_waitrequest === 1'b0) begin
            log_q.push_back({1'b1, master_address, master_writedata});
            if (master_address == 32'd0) go_cycle = cyc_no;
        end
        if (!rst && master_read === 1'b1) begin
            if (rd_run == 0) rd_first = cyc_no;
            rd_run++;
            if (master_waitrequest === 1'b0) begin
                log_q.push_back({1'b0, master_address, 32'd0});
                last_rd_len = rd_run;
                rd_run = 0;
            end
        end
        if (rst) rd_run = 0;
        pw = master_write; pwait = master_waitrequest; prst = rst;
        pa = master_address; pd = master_writedata;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        tick;
        slave_write = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
        slave_address = a; slave_read = 1'b1;
        #1;
        d = slave_readdata;
        slave_read = 1'b0;
    endtask

    task automatic push(output int stalls);
        slave_address = 4'd0; slave_writedata = 32'd0; slave_write = 1'b1;
        #1;
        stalls = 0;
        while (slave_waitrequest === 1'b1 && stalls < 2000) begin
            tick;
            stalls++;
        end
        assertions++;
        if (stalls >= 2000) begin
            failures++;
            $display("FAIL push_accept: still stalled after %0d cycles, required acceptance", stalls);
        end
        tick;
        slave_write = 1'b0;
    endtask

    task automatic wait_jobs(input logic [31:0] target);
        logic [31:0] v;
        int n = 0;
        read_reg(4'd5, v);
        while (v !== target && n < 5000) begin
            tick;
            n++;
            read_reg(4'd5, v);
        end
        assertions++;
        if (v !== target) begin
            failures++;
            $display("FAIL wait_jobs: jobs_done=%0d, required %0d", v, target);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1; slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        assertions++;
        if (master_write !== 1'b0 || master_read !== 1'b0 || slave_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: write=%b read=%b swait=%b, required 0 0 0",
                     master_write, master_read, slave_waitrequest);
        end
        assertions++;
        if (master_address !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL reset_addr: %h, required ffffffff", master_address);
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(4'(i), v);
            assertions++;
            if (v !== 32'd0) begin
                failures++;
                $display("FAIL reset_reg%0d: %h, required 0", i, v);
            end
        end
    endtask

    task automatic test_single_job;
        logic [64:0] exp_q[$];
        logic [31:0] v;
        int st;
        exp_q = '{{1'b1, 32'd4, 32'h100}, {1'b1, 32'd8, 32'h200}, {1'b1, 32'd12, 32'd3},
                  {1'b1, 32'd16, 32'd4}, {1'b1, 32'd0, 32'd1}, {1'b0, 32'd0, 32'd0}};
        log_q.delete();
        write_reg(4'd1, 32'h100);
        write_reg(4'd2, 32'h200);
        write_reg(4'd3, 32'd3);
        write_reg(4'd4, 32'd4);
        push(st);
        wait_jobs(32'd1);
        tick;
        assertions++;
        if (log_q.size() != 6) begin
            failures++;
            $display("FAIL single_log_len: %0d transfers, required 6", log_q.size());
        end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            assertions++;
            if (log_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_xfer%0d: %h, required %h", i, log_q[i], exp_q[i]);
            end
        end
        assertions++;
        if (rd_first - go_cycle != 2) begin
            failures++;
            $display("FAIL single_gap: read starts %0d cycles after go, required 2", rd_first - go_cycle);
        end
        read_reg(4'd6, v);
        assertions++;
        if (v !== 32'd7) begin
            failures++;
            $display("FAIL single_cycles: %0d, required 7", v);
        end
        read_reg(4'd0, v);
        assertions++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL single_status: %h, required 0", v);
        end
        read_reg(4'd1, v);
        assertions++;
        if (v !== 32'h100) begin
            failures++;
            $display("FAIL single_staged_src: %h, required 100", v);
        end
    endtask

    task automatic test_long_done;
        logic [31:0] v;
        int st;
        rd_hold = 50;
        push(st);
        wait_jobs(32'd2);
        tick;
        rd_hold = 0;
        assertions++;
        if (last_rd_len != 51) begin
            failures++;
            $display("FAIL long_read_len: %0d cycles, required 51", last_rd_len);
        end
        read_reg(4'd6, v);
        assertions++;
        if (v !== 32'd57) begin
            failures++;
            $display("FAIL long_cycles: %0d, required 57", v);
        end
        read_reg(4'd0, v);
        assertions++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL long_status: %h, required 0", v);
        end
    endtask

    task automatic test_fifo_full;
        logic [31:0] v;
        int st, st6, k;
        write_reg(4'd5, 32'd0);
        read_reg(4'd5, v);
        assertions++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL full_clear: %0d, required 0", v);
        end
        log_q.delete();
        stall_all = 1'b1;
        for (int j = 0; j < 5; j++) begin
            write_reg(4'd1, 32'h1000 + 32'(j));
            push(st);
        end
        repeat (3) tick;
        read_reg(4'd0, v);
        assertions++;
        if (v !== 32'h43) begin
            failures++;
            $display("FAIL full_status: %h, required 43", v);
        end
        write_reg(4'd1, 32'h1005);
        fork
            push(st6);
            begin
                repeat (20) tick;
                stall_all = 1'b0;
            end
        join
        assertions++;
        if (st6 < 20) begin
            failures++;
            $display("FAIL full_stall: sixth push stalled %0d cycles, required at least 20", st6);
        end
        read_reg(4'd0, v);
        assertions++;
        if (v !== 32'h43) begin
            failures++;
            $display("FAIL full_push_pop: %h, required 43", v);
        end
        wait_jobs(32'd6);
        k = 0;
        foreach (log_q[i]) begin
            if (log_q[i][64] && log_q[i][63:32] == 32'd4) begin
                assertions++;
                if (log_q[i][31:0] !== 32'h1000 + 32'(k)) begin
                    failures++;
                    $display("FAIL full_order%0d: src %h, required %h", k, log_q[i][31:0], 32'h1000 + 32'(k));
                end
                k++;
            end
        end
        assertions++;
        if (k != 6) begin
            failures++;
            $display("FAIL full_count: %0d jobs replayed, required 6", k);
        end
    endtask

    task automatic test_random_wait;
        logic [64:0] exp_q[$];
        int st;
        exp_q = '{{1'b1, 32'd4, 32'hA0}, {1'b1, 32'd8, 32'hB0}, {1'b1, 32'd12, 32'h11},
                  {1'b1, 32'd16, 32'h22}, {1'b1, 32'd0, 32'd1}, {1'b0, 32'd0, 32'd0},
                  {1'b1, 32'd4, 32'hC0}, {1'b1, 32'd8, 32'hB0}, {1'b1, 32'd12, 32'h33},
                  {1'b1, 32'd16, 32'h22}, {1'b1, 32'd0, 32'd1}, {1'b0, 32'd0, 32'd0}};
        tick;
        log_q.delete();
        rand_mode = 1'b1;
        write_reg(4'd1, 32'hA0);
        write_reg(4'd2, 32'hB0);
        write_reg(4'd3, 32'h11);
        write_reg(4'd4, 32'h22);
        push(st);
        write_reg(4'd1, 32'hC0);
        write_reg(4'd3, 32'h33);
        push(st);
        wait_jobs(32'd8);
        rand_mode = 1'b0;
        assertions++;
        if (log_q.size() != 12) begin
            failures++;
            $display("FAIL rand_log_len: %0d transfers, required 12", log_q.size());
        end
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            assertions++;
            if (log_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_xfer%0d: %h, required %h", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        int st, n;
        tick;
        stall_addr = 32'd12;
        write_reg(4'd1, 32'hD0);
        for (int j = 0; j < 3; j++) push(st);
        n = 0;
        while (!(master_write === 1'b1 && master_address === 32'd12) && n < 200) begin
            tick;
            n++;
        end
        read_reg(4'd0, v);
        assertions++;
        if (v !== 32'h21) begin
            failures++;
            $display("FAIL mid_status_before: %h, required 21", v);
        end
        rst = 1'b1;
        tick;
        assertions++;
        if (master_write !== 1'b0 || master_address !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mid_strobe: write=%b addr=%h, required write=0 addr=ffffffff", master_write, master_address);
        end
        read_reg(4'd0, v);
        assertions++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL mid_status: %h, required 0", v);
        end
        read_reg(4'd5, v);
        assertions++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL mid_jobs: %0d, required 0", v);
        end
        rst = 1'b0;
        stall_addr = 32'hFFFF_FFF0;
        repeat (5) tick;
        assertions++;
        if (master_write !== 1'b0 || master_read !== 1'b0) begin
            failures++;
            $display("FAIL mid_flushed: write=%b read=%b, required 0 0", master_write, master_read);
        end
    endtask

    task automatic test_clear_retire;
        logic [31:0] v;
        int st, n;
        push(st);
        wait_jobs(32'd1);
        rd_hold = 3;
        push(st);
        n = 0;
        while (master_read !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        repeat (4) tick;
        assertions++;
        if (master_read !== 1'b0) begin
            failures++;
            $display("FAIL clear_align: read=%b, required 0 in retire cycle", master_read);
        end
        write_reg(4'd5, 32'd0);
        rd_hold = 0;
        tick;
        read_reg(4'd5, v);
        assertions++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL clear_wins: jobs_done=%0d, required 0", v);
        end
        push(st);
        wait_jobs(32'd1);
    endtask

    initial begin
        test_reset;
        test_single_job;
        test_long_done;
        test_fifo_full;
        test_random_wait;
        test_reset_mid;
        test_clear_retire;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
